latch_bank: RTL and testbench
=============================

LATCH_BANK -- requirements
Module: latch_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data bits per channel (legal range 1..64).
REQ-002 Parameter CH, default 4, SHALL set the channel count (legal range 1..32).
REQ-003 Parameter MODE, default 0, SHALL select the capture mode: 0 = level (capture every enabled cycle), 1 = edge (capture on ena 0->1 only).
REQ-004 Out-of-range WIDTH, CH or MODE SHALL cause an elaboration error.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clr  in  1  synchronous clear of all channels.
REQ-009 in  in  CH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 ena  in  CH  per-channel capture enable.
REQ-011 ack  in  CH  per-channel consumer acknowledge; clears fresh.
REQ-012 out  out  CH*WIDTH  held data per channel, same packing as in.
REQ-013 fresh  out  CH  per-channel unread-data flag.
REQ-014 ovr  out  CH  per-channel sticky overrun flag.
REQ-015 upd  out  CH  per-channel one-cycle update pulse.

Function
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from in, ena, ack or clr to any output.
REQ-017 Capture condition cap[i]: MODE 0 -> ena[i]=1; MODE 1 -> ena[i]=1 and ena_q[i]=0, where ena_q is ena registered every cycle.
REQ-018 On a clk edge with cap[i]=1 and clr=0, out_i SHALL load in_i, giving one-cycle latency from in to out.
REQ-019 With cap[i]=0, out_i SHALL hold its value indefinitely.
REQ-020 upd[i] SHALL be 1 in exactly the cycle after each capture, coincident with the new out_i, and 0 otherwise.
REQ-021 fresh[i] next-state SHALL be: clr -> 0; else cap[i] -> 1; else ack[i] -> 0; else hold.
REQ-022 A capture and an ack in the same cycle SHALL leave fresh[i]=1; the ack refers to the old data.
REQ-023 ovr[i] SHALL be set when cap[i]=1, fresh[i]=1 and ack[i]=0, and SHALL remain set until clr or reset.
REQ-024 A capture with ack[i]=1 SHALL NOT set ovr[i].
REQ-025 In MODE 0, consecutive enabled cycles without ack SHALL set ovr[i]; this is defined behaviour.
REQ-026 clr SHALL take priority over capture: out, fresh, ovr and upd go to 0 at that edge.
REQ-027 In MODE 1, clr SHALL NOT clear ena_q; ena_q always tracks ena.
REQ-028 Channels SHALL be fully independent, with no cross-channel interaction except the shared clr.
REQ-029 ack[i] with fresh[i]=0 SHALL have no effect.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately drive out, fresh, ovr and upd to 0 and ena_q to 0, regardless of clk.
REQ-031 In MODE 1, ena held at 1 through reset release SHALL capture on the first clk edge after release, because ena_q is 0.
REQ-032 Reset asserted mid-stream SHALL discard any pending capture; no upd pulse SHALL follow release unless a new capture occurs.

Verification
REQ-033 Scenario 1: MODE 0, CH=4, WIDTH=8, ena=0001, in ch0=0x5A for one cycle -> next cycle out ch0=0x5A, upd=0001, fresh=0001; ch1..3 stay 0.
REQ-034 Scenario 2: MODE 1, ena[0] held high 5 cycles with in changing 0x11..0x15 -> exactly one capture (0x11), upd pulses once, ovr=0.
REQ-035 Scenario 3: two captures on ch2 with no ack -> ovr[2]=1 after the second; ack then clears fresh[2] but ovr[2] stays 1 until clr.
REQ-036 Scenario 4: cap and ack on ch1 in the same cycle with fresh[1]=1 -> fresh[1]=1, ovr[1]=0, out ch1 = new data.
REQ-037 Scenario 5: clr and ena=1111 in the same cycle -> all out=0, fresh=0, ovr=0, upd=0 the next cycle.
REQ-038 Scenario 6: rst_n pulsed low between clk edges mid-capture -> outputs 0 immediately; MODE 1 with ena high at release -> capture on the first edge.

Source files
------------

// File: rtl/latch_bank.sv
// Per-channel capture latch bank with unread (fresh), sticky overrun (ovr) and update-pulse flags.
// Outputs are registered one cycle after capture; the block has no backpressure and ack only retires fresh.
module latch_bank #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int MODE  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [CH*WIDTH-1:0] in,
  input  logic [CH-1:0]       ena,
  input  logic [CH-1:0]       ack,
  output logic [CH*WIDTH-1:0] out,
  output logic [CH-1:0]       fresh,
  output logic [CH-1:0]       ovr,
  output logic [CH-1:0]       upd
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("latch_bank: WIDTH must be in 1..64");
  end
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("latch_bank: CH must be in 1..32");
  end
  if (MODE < 0 || MODE > 1) begin : g_bad_mode
    $error("latch_bank: MODE must be 0 or 1");
  end

  logic [CH*WIDTH-1:0] out_q, out_d;
  logic [CH-1:0]       fresh_q, fresh_d;
  logic [CH-1:0]       ovr_q, ovr_d;
  logic [CH-1:0]       upd_q, upd_d;
  logic [CH-1:0]       ena_q;
  logic [CH-1:0]       cap;

  // ena_q follows ena every cycle, even through clr, so edge detection is unaffected by clearing
  assign cap = (MODE == 1) ? (ena & ~ena_q) : ena;

  always_comb begin
    out_d   = out_q;
    fresh_d = fresh_q;
    ovr_d   = ovr_q;
    upd_d   = '0;
    if (clr) begin
      out_d   = '0;
      fresh_d = '0;
      ovr_d   = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cap[i]) out_d[i*WIDTH +: WIDTH] = in[i*WIDTH +: WIDTH];
      end
      // A same-cycle ack retires the old data, so it neither clears fresh nor counts as overrun
      fresh_d = cap | (fresh_q & ~ack);
      ovr_d   = ovr_q | (cap & fresh_q & ~ack);
      upd_d   = cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      fresh_q <= '0;
      ovr_q   <= '0;
      upd_q   <= '0;
      ena_q   <= '0;
    end else begin
      out_q   <= out_d;
      fresh_q <= fresh_d;
      ovr_q   <= ovr_d;
      upd_q   <= upd_d;
      ena_q   <= ena;
    end
  end

  assign out   = out_q;
  assign fresh = fresh_q;
  assign ovr   = ovr_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_latch_bank.sv
// Bench for latch_bank: a level-mode and an edge-mode instance share stimulus; a reference model
// pushes expected outputs per cycle into a queue that each scenario pops and compares.
module tb_latch_bank;

  typedef struct packed {
    logic [31:0] out;
    logic [3:0]  fresh;
    logic [3:0]  ovr;
    logic [3:0]  upd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] din;
  logic [3:0]  ena;
  logic [3:0]  ack;
  logic [31:0] out0, out1;
  logic [3:0]  fresh0, fresh1, ovr0, ovr1, upd0, upd1;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [31:0] m_out  [2];
  logic [3:0]  m_fresh[2];
  logic [3:0]  m_ovr  [2];
  logic [3:0]  m_upd  [2];
  logic [3:0]  m_enaq [2];

  latch_bank #(.WIDTH(8), .CH(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in(din), .ena(ena), .ack(ack),
    .out(out0), .fresh(fresh0), .ovr(ovr0), .upd(upd0)
  );

  latch_bank #(.WIDTH(8), .CH(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in(din), .ena(ena), .ack(ack),
    .out(out1), .fresh(fresh1), .ovr(ovr1), .upd(upd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]   = '0;
      m_fresh[k] = '0;
      m_ovr[k]   = '0;
      m_upd[k]   = '0;
      m_enaq[k]  = '0;
    end
  endtask

  // Advance the reference model by one clock using current inputs, queue the expectation, then clock the DUTs
  task automatic tick();
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic c;
        c = (k == 1) ? (ena[i] && !m_enaq[k][i]) : ena[i];
        if (clr) begin
          m_out[k][i*8 +: 8] = 8'h00;
          m_fresh[k][i] = 1'b0;
          m_ovr[k][i]   = 1'b0;
          m_upd[k][i]   = 1'b0;
        end else if (c) begin
          m_out[k][i*8 +: 8] = din[i*8 +: 8];
          if (m_fresh[k][i] && !ack[i]) m_ovr[k][i] = 1'b1;
          m_fresh[k][i] = 1'b1;
          m_upd[k][i]   = 1'b1;
        end else begin
          if (ack[i]) m_fresh[k][i] = 1'b0;
          m_upd[k][i] = 1'b0;
        end
      end
      m_enaq[k] = ena;
      x = '{out: m_out[k], fresh: m_fresh[k], ovr: m_ovr[k], upd: m_upd[k]};
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 0; din = '0; ena = '0; ack = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({out0, fresh0, ovr0, upd0} !== 44'h0) begin
      bad++;
      $display("FAIL reset_d0 got=%h required=0", {out0, fresh0, ovr0, upd0});
    end
    total++;
    if ({out1, fresh1, ovr1, upd1} !== 44'h0) begin
      bad++;
      $display("FAIL reset_d1 got=%h required=0", {out1, fresh1, ovr1, upd1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_level_capture();
    clr = 1; ena = '0; ack = '0; din = '0;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    clr = 0;
    din = {8'hC1, 8'hB2, 8'hA3, 8'h5A};
    ena = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL level_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL level_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
      if (c == 0) begin
        total++;
        if (out0 !== 32'h0000005A || upd0 !== 4'b0001 || fresh0 !== 4'b0001) begin
          bad++; $display("FAIL scen1 got out=%h upd=%b fresh=%b required out=0000005a upd=0001 fresh=0001", out0, upd0, fresh0);
        end
      end
      ena = '0;
      din = $urandom;
    end
  endtask

  task automatic test_edge_mode();
    int pulses;
    clr = 1; ena = '0; ack = '0;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    clr = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      ena = (c < 5) ? 4'b0001 : 4'b0000;
      din = {24'h0, 8'(8'h11 + c)};
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL edge_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL edge_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
      if (upd1[0]) pulses++;
    end
    total++;
    if (pulses != 1 || out1[7:0] !== 8'h11 || ovr1[0] !== 1'b0) begin
      bad++; $display("FAIL scen2 got pulses=%0d out=%h ovr=%b required pulses=1 out=11 ovr=0", pulses, out1[7:0], ovr1[0]);
    end
    total++;
    if (ovr0[0] !== 1'b1 || out0[7:0] !== 8'h15) begin
      bad++; $display("FAIL level_repeat got ovr=%b out=%h required ovr=1 out=15", ovr0[0], out0[7:0]);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] ena_seq [6];
    logic [3:0] ack_seq [6];
    logic [3:0] clr_seq;
    ena_seq = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    ack_seq = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111};
    clr_seq = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      clr = (c == 0) || (c == 6);
      ena = (c < 6) ? ena_seq[c] : 4'b0000;
      ack = (c < 6) ? ack_seq[c] : 4'b0000;
      din = $urandom;
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL ovr_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL ovr_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
      if (c == 4) begin
        total++;
        if (ovr0[2] !== 1'b1 || ovr1[2] !== 1'b1 || fresh0[2] !== 1'b0) begin
          bad++; $display("FAIL scen3 got ovr0=%b ovr1=%b fresh=%b required 1 1 0", ovr0[2], ovr1[2], fresh0[2]);
        end
      end
    end
    total++;
    if (ovr0 !== 4'b0000 || ovr1 !== 4'b0000 || clr_seq !== 4'b0001) begin
      bad++; $display("FAIL ovr_clr got ovr0=%b ovr1=%b required 0000", ovr0, ovr1);
    end
  endtask

  task automatic test_cap_ack();
    clr = 1; ena = '0; ack = '0;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    clr = 0;
    for (int c = 0; c < 4; c++) begin
      ena = (c == 0 || c == 2) ? 4'b0010 : 4'b0000;
      ack = (c == 2) ? 4'b0010 : (c == 3 ? 4'b1101 : 4'b0000);
      din = (c == 2) ? 32'h0000C300 : 32'h00004400;
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL capack_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL capack_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
      if (c == 2) begin
        total++;
        if (fresh1[1] !== 1'b1 || ovr1[1] !== 1'b0 || out1[15:8] !== 8'hC3 || ovr0[1] !== 1'b0) begin
          bad++; $display("FAIL scen4 got fresh=%b ovr=%b out=%h required fresh=1 ovr=0 out=c3", fresh1[1], ovr1[1], out1[15:8]);
        end
      end
    end
  endtask

  task automatic test_clr_priority();
    for (int c = 0; c < 3; c++) begin
      clr = (c == 1);
      ena = (c == 0) ? 4'b0000 : 4'b1111;
      ack = '0;
      din = $urandom;
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL clr_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL clr_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
      if (c == 1) begin
        total++;
        if ({out0, fresh0, ovr0, upd0, out1, fresh1, ovr1, upd1} !== 88'h0) begin
          bad++; $display("FAIL scen5 got d0=%h d1=%h required all zero", {out0, fresh0, ovr0, upd0}, {out1, fresh1, ovr1, upd1});
        end
      end
      if (c == 2) begin
        total++;
        if (upd1 !== 4'b0000 || upd0 !== 4'b1111) begin
          bad++; $display("FAIL clr_enaq got upd1=%b upd0=%b required upd1=0000 upd0=1111", upd1, upd0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clr = 1; ena = '0; ack = '0;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    clr = 0;
    for (int c = 0; c < 3; c++) begin
      ena = 4'b1111;
      ack = (c == 0) ? 4'b0000 : 4'b0101;
      din = $urandom;
      tick();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      total++;
      if ({out0, fresh0, ovr0, upd0} !== e0) begin
        bad++; $display("FAIL b2b_d0 cyc%0d got=%h required=%h", c, {out0, fresh0, ovr0, upd0}, e0);
      end
      total++;
      if ({out1, fresh1, ovr1, upd1} !== e1) begin
        bad++; $display("FAIL b2b_d1 cyc%0d got=%h required=%h", c, {out1, fresh1, ovr1, upd1}, e1);
      end
    end
    total++;
    if (ovr0 !== 4'b1010 || ovr1 !== 4'b0000 || out0 !== din) begin
      bad++; $display("FAIL b2b_ovr got ovr0=%b ovr1=%b out0=%h required 1010 0000 %h", ovr0, ovr1, out0, din);
    end
  endtask

  task automatic test_async_reset();
    clr = 1; ena = '0; ack = '0;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    clr = 0;
    ena = 4'b0001;
    din = 32'h00000077;
    tick();
    void'(q0.pop_front()); void'(q1.pop_front());
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({out0, fresh0, ovr0, upd0, out1, fresh1, ovr1, upd1} !== 88'h0) begin
      bad++; $display("FAIL async_rst got d0=%h d1=%h required all zero", {out0, fresh0, ovr0, upd0}, {out1, fresh1, ovr1, upd1});
    end
    din = 32'h00000088;
    #2 rst_n = 1'b1;
    tick();
    e0 = q0.pop_front(); e1 = q1.pop_front();
    total++;
    if ({out1, fresh1, ovr1, upd1} !== e1 || {out0, fresh0, ovr0, upd0} !== e0) begin
      bad++; $display("FAIL rst_release got d0=%h d1=%h required d0=%h d1=%h", {out0, fresh0, ovr0, upd0}, {out1, fresh1, ovr1, upd1}, e0, e1);
    end
    total++;
    if (upd1 !== 4'b0001 || out1[7:0] !== 8'h88) begin
      bad++; $display("FAIL scen6 got upd1=%b out=%h required upd1=0001 out=88", upd1, out1[7:0]);
    end
    ena = 4'b0010;
    din = 32'h00009900;
    #2 rst_n = 1'b0;
    model_reset();
    ena = 4'b0000;
    #2 rst_n = 1'b1;
    tick();
    e0 = q0.pop_front(); e1 = q1.pop_front();
    total++;
    if ({out0, fresh0, ovr0, upd0} !== e0 || {out1, fresh1, ovr1, upd1} !== e1 || upd0 !== 4'b0000) begin
      bad++; $display("FAIL rst_discard got d0=%h d1=%h required d0=%h d1=%h", {out0, fresh0, ovr0, upd0}, {out1, fresh1, ovr1, upd1}, e0, e1);
    end
  endtask

  initial begin
    test_reset();
    test_level_capture();
    test_edge_mode();
    test_overrun();
    test_cap_ack();
    test_clr_priority();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
